// File: rtl/duc_feed_pkg.sv
// duc_feed_pkg: shared state encoding and word widths for the DUC sample feeder
package duc_feed_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAST = 2'd2, ERR = 2'd3} state_t;
  localparam int SAMPLE_W = 32;
  localparam int WORD_W = SAMPLE_W + 1;
endpackage

// File: rtl/duc_feed_fifo.sv
// duc_feed_fifo: synchronous FIFO, callers must only push when not full and pop when not empty
module duc_feed_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int W = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          din,
  output logic [W-1:0]          head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);
  logic [W-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wp, rp;
  assign head = mem[rp];
  assign full = level == (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  assign empty = level == '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + DEPTH_LOG2'(push);
      rp <= rp + DEPTH_LOG2'(pop);
      level <= level + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    end
endmodule

// File: rtl/duc_sample_feeder.sv
// duc_sample_feeder: buffers IQ samples and releases one per DUC strobe with burst priming,
// tlast handling and underrun recovery.
module duc_sample_feeder
  import duc_feed_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int PRIME_LEVEL = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [SAMPLE_W-1:0]   in_tdata,
  input  logic                  in_tlast,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  output logic [SAMPLE_W-1:0]   sample,
  output logic                  run,
  input  logic                  strobe,
  output logic                  underrun,
  output logic                  burst_ack,
  output logic [CNT_WIDTH-1:0]  underrun_count,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic [1:0]            state_dbg
);
  if (PRIME_LEVEL < 1 || PRIME_LEVEL > 2**DEPTH_LOG2) begin : g_bad_prime
    $error("PRIME_LEVEL out of range");
  end
  state_t state;
  logic [WORD_W-1:0] head;
  logic full, empty, push, pop;
  logic [DEPTH_LOG2:0] last_pending;
  assign in_tready = ~full;
  assign push = in_tvalid & ~full;
  assign pop = ~empty & ((state == RUN & strobe) | state == ERR);
  assign state_dbg = state;
  duc_feed_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(WORD_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .pop(pop),
    .din({in_tlast, in_tdata}), .head(head), .full(full), .empty(empty), .level(fill_level)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sample <= '0;
      run <= 1'b0;
      underrun <= 1'b0;
      burst_ack <= 1'b0;
      underrun_count <= '0;
      last_pending <= '0;
    end else if (clr) begin
      state <= IDLE;
      sample <= '0;
      run <= 1'b0;
      underrun <= 1'b0;
      burst_ack <= 1'b0;
      underrun_count <= '0;
      last_pending <= '0;
    end else begin
      underrun <= 1'b0;
      burst_ack <= 1'b0;
      last_pending <= last_pending + (DEPTH_LOG2+1)'(push & in_tlast) - (DEPTH_LOG2+1)'(pop & head[SAMPLE_W]);
      case (state)
        IDLE: if (fill_level >= (DEPTH_LOG2+1)'(PRIME_LEVEL) || last_pending != '0) begin
          state <= RUN;
          run <= 1'b1;
        end
        RUN: if (strobe) begin
          if (!empty) begin
            sample <= head[SAMPLE_W-1:0];
            if (head[SAMPLE_W]) state <= LAST;
          end else begin
            sample <= '0;
            run <= 1'b0;
            underrun <= 1'b1;
            if (~&underrun_count) underrun_count <= underrun_count + CNT_WIDTH'(1);
            state <= ERR;
          end
        end
        LAST: if (strobe) begin
          sample <= '0;
          run <= 1'b0;
          burst_ack <= 1'b1;
          state <= IDLE;
        end
        ERR: if (pop && head[SAMPLE_W]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_duc_sample_feeder.sv
// tb_duc_sample_feeder: directed checks of priming, bursts, underrun, backpressure, saturation and clears
module tb_duc_sample_feeder;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_tlast = 1'b0, in_tvalid = 1'b0, strobe = 1'b0;
  logic [31:0] in_tdata = '0;
  logic in_tready, run, underrun, burst_ack;
  logic [31:0] sample;
  logic [15:0] underrun_count;
  logic [4:0] fill_level;
  logic [1:0] state_dbg;
  logic in_tready2, run2, underrun2, burst_ack2;
  logic [31:0] sample2;
  logic [1:0] underrun_count2;
  logic [4:0] fill_level2;
  logic [1:0] state_dbg2;
  int checks = 0, errors = 0, accepted;
  always #5 clk = ~clk;
  duc_sample_feeder dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_tdata(in_tdata), .in_tlast(in_tlast),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .sample(sample), .run(run), .strobe(strobe),
    .underrun(underrun), .burst_ack(burst_ack), .underrun_count(underrun_count),
    .fill_level(fill_level), .state_dbg(state_dbg)
  );
  duc_sample_feeder #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_tdata(in_tdata), .in_tlast(in_tlast),
    .in_tvalid(in_tvalid), .in_tready(in_tready2), .sample(sample2), .run(run2), .strobe(strobe),
    .underrun(underrun2), .burst_ack(burst_ack2), .underrun_count(underrun_count2),
    .fill_level(fill_level2), .state_dbg(state_dbg2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] d, input logic l);
    in_tdata = d;
    in_tlast = l;
    in_tvalid = 1'b1;
    tick();
    in_tvalid = 1'b0;
    in_tlast = 1'b0;
  endtask
  task automatic strb();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_sample", sample, 0);
    chk("rst_run", {31'd0, run}, 0);
    chk("rst_state", {30'd0, state_dbg}, 0);
    chk("rst_fill", {27'd0, fill_level}, 0);
    chk("rst_count", {16'd0, underrun_count}, 0);
    chk("rst_tready", {31'd0, in_tready}, 1);
    rst_n = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) push(32'h00010001 * i, 1'b0);
    chk("prime_fill", {27'd0, fill_level}, 4);
    chk("prime_run_early", {31'd0, run}, 0);
    tick();
    chk("prime_run", {31'd0, run}, 1);
    chk("prime_state", {30'd0, state_dbg}, 1);
    for (int i = 1; i <= 4; i++) begin
      strb();
      chk("prime_sample", sample, 32'h00010001 * i);
      chk("prime_fill_dec", {27'd0, fill_level}, 4 - i);
      tick();
      tick();
      tick();
    end
    strb();
    chk("ur_pulse", {31'd0, underrun}, 1);
    chk("ur_count", {16'd0, underrun_count}, 1);
    chk("ur_run", {31'd0, run}, 0);
    chk("ur_sample", sample, 0);
    chk("ur_state", {30'd0, state_dbg}, 3);
    tick();
    chk("ur_pulse_end", {31'd0, underrun}, 0);
    push(32'hA, 1'b0);
    push(32'hB, 1'b0);
    push(32'hC, 1'b1);
    chk("err_state", {30'd0, state_dbg}, 3);
    tick();
    chk("err_idle", {30'd0, state_dbg}, 0);
    chk("err_fill", {27'd0, fill_level}, 0);
    tick();
    chk("err_stay_idle", {30'd0, state_dbg}, 0);
    push(32'h11112222, 1'b0);
    push(32'h33334444, 1'b1);
    chk("sb_idle", {30'd0, state_dbg}, 0);
    tick();
    chk("sb_run", {31'd0, run}, 1);
    strb();
    chk("sb_s1", sample, 32'h11112222);
    strb();
    chk("sb_s2", sample, 32'h33334444);
    chk("sb_last", {30'd0, state_dbg}, 2);
    tick();
    chk("sb_hold", sample, 32'h33334444);
    strb();
    chk("sb_ack", {31'd0, burst_ack}, 1);
    chk("sb_run0", {31'd0, run}, 0);
    chk("sb_sample0", sample, 0);
    chk("sb_state0", {30'd0, state_dbg}, 0);
    tick();
    chk("sb_ack_end", {31'd0, burst_ack}, 0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) push(32'h100 + i, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) strb();
      push(32'hDEAD, 1'b1);
      tick();
      chk("sat_idle", {30'd0, state_dbg}, 0);
    end
    chk("sat_count16", {16'd0, underrun_count}, 4);
    chk("sat_count2", {30'd0, underrun_count2}, 3);
    accepted = 0;
    in_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_tdata = 32'h200 + i;
      if (in_tready) accepted++;
      tick();
    end
    in_tvalid = 1'b0;
    chk("bp_accepted", accepted, 16);
    chk("bp_fill", {27'd0, fill_level}, 16);
    chk("bp_tready", {31'd0, in_tready}, 0);
    chk("bp_state", {30'd0, state_dbg}, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_state", {30'd0, state_dbg}, 0);
    chk("clr_run", {31'd0, run}, 0);
    chk("clr_fill", {27'd0, fill_level}, 0);
    chk("clr_pulses", {30'd0, underrun, burst_ack}, 0);
    chk("clr_count", {16'd0, underrun_count}, 0);
    chk("clr_tready", {31'd0, in_tready}, 1);
    for (int i = 1; i <= 5; i++) push(32'h300 + i, 1'b0);
    tick();
    strb();
    chk("ar_sample_pre", sample, 32'h301);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sample", sample, 0);
    chk("ar_run", {31'd0, run}, 0);
    chk("ar_fill", {27'd0, fill_level}, 0);
    chk("ar_state", {30'd0, state_dbg}, 0);
    rst_n = 1'b1;
    tick();
    chk("ar_run_after", {31'd0, run}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
